vga_sync_gen: RTL and testbench

Generates 640x480@60 Hz VGA timing: the horizontal/vertical position counters `hPos`/`vPos`, the active-low sync pulses, a visible-area flag and per-pixel/per-frame strobes. It is the producer of the `hPos`/`vPos` coordinates consumed by the colour-blanking stage and the sprite/game logic. It sits directly behind the board clock, and its sync outputs go straight to the VGA connector.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_sync_gen_pixel_tick_gen.sv | 35 +++
 rtl/vga_sync_gen.sv | 100 ++++++++++
 tb/tb_vga_sync_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 Hz timing constants and the
// shared 10-bit screen-position type.
package vga_timing_pkg;

    typedef logic [9:0] pos_t;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF
                           + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF
                           + V_SYNC_DEF + V_BACK_DEF;

    localparam int H_SYNC_START = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
    localparam int V_SYNC_START = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

    function automatic pos_t wrap_inc(input pos_t p, input pos_t last);
        return (p == last) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// pixel_tick_gen: divides the system clock down to a one-cycle
// pixel strobe every CLK_DIV clocks.
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("pixel_tick_gen: CLK_DIV must be at least 1");
    end

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA position counters with registered sync, visible
// and frame-start outputs aligned to the counter values they describe.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic pixelTick,
    output pos_t hPos,
    output pos_t vPos,
    output logic hSync,
    output logic vSync,
    output logic visible,
    output logic frameStart
);

    localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam pos_t H_LAST = pos_t'(HT - 1);
    localparam pos_t V_LAST = pos_t'(VT - 1);
    localparam pos_t H_VIS  = pos_t'(H_VISIBLE);
    localparam pos_t V_VIS  = pos_t'(V_VISIBLE);
    localparam pos_t H_SS   = pos_t'(H_VISIBLE + H_FRONT);
    localparam pos_t H_SE   = pos_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam pos_t V_SS   = pos_t'(V_VISIBLE + V_FRONT);
    localparam pos_t V_SE   = pos_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    if (HT > 1024 || VT > 1024) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must be <= 1024");
    end

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (pixelTick)
    );

    pos_t h_q, h_d;
    pos_t v_q, v_d;
    logic hs_q, hs_d;
    logic vs_q, vs_d;
    logic vis_q, vis_d;
    logic fs_q, fs_d;

    // Decode from next-state counters so flags line up with hPos/vPos.
    always_comb begin
        h_d  = h_q;
        v_d  = v_q;
        fs_d = 1'b0;
        if (pixelTick) begin
            h_d = wrap_inc(h_q, H_LAST);
            if (h_q == H_LAST) begin
                v_d  = wrap_inc(v_q, V_LAST);
                fs_d = (v_q == V_LAST);
            end
        end
        hs_d  = !((h_d >= H_SS) && (h_d <= H_SE));
        vs_d  = !((v_d >= V_SS) && (v_d <= V_SE));
        vis_d = (h_d < H_VIS) && (v_d < V_VIS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q   <= '0;
            v_q   <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            vis_q <= 1'b1;
            fs_q  <= 1'b0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            vis_q <= vis_d;
            fs_q  <= fs_d;
        end
    end

    assign hPos       = h_q;
    assign vPos       = v_q;
    assign hSync      = hs_q;
    assign vSync      = vs_q;
    assign visible    = vis_q;
    assign frameStart = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: three configurations (full-size default, shrunk
// timing at CLK_DIV 2 and 1) checked cycle by cycle against a model.
module tb_vga_sync_gen;
    import vga_timing_pkg::*;

    typedef struct {
        int tick;
        int h;
        int v;
        int hs;
        int vs;
        int vis;
        int fs;
    } obs_t;

    typedef struct {
        int d;
        int hv, hf, hsy, hb;
        int vv, vf, vsy, vb;
    } cfg_t;

    cfg_t C_DEF = '{2, 640, 16, 96, 48, 480, 10, 2, 33};
    cfg_t C_S2  = '{2, 8, 2, 3, 2, 5, 1, 2, 2};
    cfg_t C_S1  = '{1, 8, 2, 3, 2, 5, 1, 2, 2};

    logic clk;
    logic rst;

    logic pt_def, hs_def, vs_def, vis_def, fs_def;
    logic pt_s2, hs_s2, vs_s2, vis_s2, fs_s2;
    logic pt_s1, hs_s1, vs_s1, vis_s1, fs_s1;
    pos_t h_def, v_def, h_s2, v_s2, h_s1, v_s1;

    int n_chk;
    int n_fail;
    longint c;
    obs_t q_def[$];
    obs_t q_s2[$];
    obs_t q_s1[$];

    vga_sync_gen u_def (
        .clk(clk), .rst(rst), .pixelTick(pt_def),
        .hPos(h_def), .vPos(v_def), .hSync(hs_def),
        .vSync(vs_def), .visible(vis_def), .frameStart(fs_def)
    );

    vga_sync_gen #(
        .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3),
        .H_BACK(2), .V_VISIBLE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) u_s2 (
        .clk(clk), .rst(rst), .pixelTick(pt_s2),
        .hPos(h_s2), .vPos(v_s2), .hSync(hs_s2),
        .vSync(vs_s2), .visible(vis_s2), .frameStart(fs_s2)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3),
        .H_BACK(2), .V_VISIBLE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) u_s1 (
        .clk(clk), .rst(rst), .pixelTick(pt_s1),
        .hPos(h_s1), .vPos(v_s1), .hSync(hs_s1),
        .vSync(vs_s1), .visible(vis_s1), .frameStart(fs_s1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // c = clocks since the last reset edge; ticks consumed = c / d.
    function automatic obs_t model(input longint cc, input cfg_t g);
        obs_t e;
        longint n;
        int ht, vt, h, v, hss, vss;
        ht  = g.hv + g.hf + g.hsy + g.hb;
        vt  = g.vv + g.vf + g.vsy + g.vb;
        n   = cc / g.d;
        h   = int'(n % ht);
        v   = int'((n / ht) % vt);
        hss = g.hv + g.hf;
        vss = g.vv + g.vf;
        e.tick = ((cc + 1) % g.d == 0) ? 1 : 0;
        e.h    = h;
        e.v    = v;
        e.hs   = (h >= hss && h < hss + g.hsy) ? 0 : 1;
        e.vs   = (v >= vss && v < vss + g.vsy) ? 0 : 1;
        e.vis  = (h < g.hv && v < g.vv) ? 1 : 0;
        e.fs   = (cc > 0 && cc % g.d == 0
                  && n % (ht * vt) == 0) ? 1 : 0;
        return e;
    endfunction

    function automatic obs_t pack(input logic pt, input pos_t h,
                                  input pos_t v, input logic hs,
                                  input logic vs, input logic vis,
                                  input logic fs);
        obs_t a;
        a.tick = int'(pt);
        a.h    = int'(h);
        a.v    = int'(v);
        a.hs   = int'(hs);
        a.vs   = int'(vs);
        a.vis  = int'(vis);
        a.fs   = int'(fs);
        return a;
    endfunction

    task automatic cmp1(input string nm, input int a, input int e);
        n_chk++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d at t=%0t",
                     nm, a, e, $time);
        end
    endtask

    task automatic cmp(input string tag, input obs_t a, input obs_t e);
        cmp1({tag, ".pixelTick"}, a.tick, e.tick);
        cmp1({tag, ".hPos"}, a.h, e.h);
        cmp1({tag, ".vPos"}, a.v, e.v);
        cmp1({tag, ".hSync"}, a.hs, e.hs);
        cmp1({tag, ".vSync"}, a.vs, e.vs);
        cmp1({tag, ".visible"}, a.vis, e.vis);
        cmp1({tag, ".frameStart"}, a.fs, e.fs);
    endtask

    task automatic empty_fail(input string tag);
        n_chk++;
        n_fail++;
        $display("FAIL %s scoreboard empty got 0 expected 1 at t=%0t",
                 tag, $time);
    endtask

    // Reference side: one expected record per DUT per clock edge.
    initial begin
        c = 0;
        forever begin
            @(posedge clk);
            if (rst) c = 0;
            else c = c + 1;
            q_def.push_back(model(c, C_DEF));
            q_s2.push_back(model(c, C_S2));
            q_s1.push_back(model(c, C_S1));
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (q_def.size() == 0) empty_fail("def");
            else cmp("def", pack(pt_def, h_def, v_def, hs_def,
                                 vs_def, vis_def, fs_def),
                     q_def.pop_front());
            if (q_s2.size() == 0) empty_fail("s2");
            else cmp("s2", pack(pt_s2, h_s2, v_s2, hs_s2,
                                vs_s2, vis_s2, fs_s2),
                     q_s2.pop_front());
            if (q_s1.size() == 0) empty_fail("s1");
            else cmp("s1", pack(pt_s1, h_s1, v_s1, hs_s1,
                                vs_s1, vis_s1, fs_s1),
                     q_s1.pop_front());
        end
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (4000) @(posedge clk);
        for (int k = 0; k < 24; k++) begin
            repeat ($urandom_range(20, 400)) @(posedge clk);
            #2 rst = 1'b1;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #2 rst = 1'b0;
        end
        repeat (300) @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
